// File: rtl/sv_classify_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sv_classify_sequencer: SV fetch / MAC drain / class decision controller. Rev 1.0 |
// +--------------------------------------------------------------------------+
module sv_classify_sequencer #(
  parameter int MAX_SV  = 100,
  parameter int ADDR_W  = 7,
  parameter int MAC_LAT = 2,
  parameter int FX_W    = 48
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              test_valid,
  input  logic [8:0]        test_x,
  output logic              test_ready,
  input  logic [ADDR_W-1:0] cfg_num_sv,
  output logic              sv_rd_en,
  output logic [ADDR_W-1:0] sv_addr,
  input  logic [8:0]        sv_alpha,
  input  logic [8:0]        sv_x,
  input  logic [1:0]        sv_y,
  output logic              mac_clear,
  output logic              mac_en,
  output logic [8:0]        mac_alpha,
  output logic [8:0]        mac_xtest,
  output logic [8:0]        mac_xsv,
  output logic [1:0]        mac_y,
  input  logic [FX_W-1:0]   mac_fx,
  output logic              res_valid,
  output logic [1:0]        res_class,
  input  logic              res_ready,
  output logic              busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DRAIN  = 3'd2;
  localparam logic [2:0] S_DECIDE = 3'd3;
  localparam logic [2:0] S_HOLD   = 3'd4;

  localparam int                DW    = $clog2(MAC_LAT + 2);
  localparam logic [ADDR_W-1:0] MAX_N = ADDR_W'(MAX_SV);

  logic [2:0]        state;
  logic [ADDR_W-1:0] num_sv;
  logic [DW-1:0]     drain_cnt;
  logic [ADDR_W-1:0] cfg_sat;
  logic              accept;
  logic              fx_pos;

  assign test_ready = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign accept     = test_valid && test_ready;
  assign cfg_sat    = (cfg_num_sv > MAX_N) ? MAX_N : cfg_num_sv;
  // Strictly positive only: a zero decision value classifies as -1.
  assign fx_pos     = !mac_fx[FX_W-1] && (|mac_fx[FX_W-2:0]);

  assign mac_alpha = sv_alpha;
  assign mac_xsv   = sv_x;
  assign mac_y     = sv_y;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      num_sv    <= '0;
      drain_cnt <= '0;
      sv_rd_en  <= 1'b0;
      sv_addr   <= '0;
      mac_en    <= 1'b0;
      mac_clear <= 1'b0;
      mac_xtest <= '0;
      res_valid <= 1'b0;
      res_class <= '0;
    end else begin
      mac_clear <= 1'b0;
      // Read data arrives one cycle after the strobe, so accumulate then.
      mac_en    <= sv_rd_en;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mac_xtest <= test_x;
            num_sv    <= cfg_sat;
            mac_clear <= 1'b1;
            sv_addr   <= '0;
            drain_cnt <= '0;
            if (cfg_sat != '0) begin
              sv_rd_en <= 1'b1;
              state    <= S_FETCH;
            end else begin
              state    <= S_DRAIN;
            end
          end
        end
        S_FETCH: begin
          if (sv_addr == num_sv - ADDR_W'(1)) begin
            sv_rd_en <= 1'b0;
            state    <= S_DRAIN;
          end else begin
            sv_addr  <= sv_addr + ADDR_W'(1);
          end
        end
        S_DRAIN: begin
          // MAC_LAT+1 cycles: one for the read-data register plus the MAC pipe.
          if (drain_cnt == DW'(MAC_LAT)) begin
            state     <= S_DECIDE;
          end else begin
            drain_cnt <= drain_cnt + DW'(1);
          end
        end
        S_DECIDE: begin
          res_class <= fx_pos ? 2'b01 : 2'b11;
          res_valid <= 1'b1;
          state     <= S_HOLD;
        end
        S_HOLD: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/sv_classify_sequencer.md
Name: sv_classify_sequencer

Overview:
Controller that sequences the polynomial-kernel SVM classification datapath for one test sample at a time. It accepts a test sample over a valid/ready handshake, streams the stored support vectors (alpha, X, Y) from SV memory into the kernel-MAC datapath, and waits out the MAC pipeline. It then thresholds the accumulated decision value and presents the class label over a second valid/ready handshake. It sits between the sample source, the SV memory, and the kernel-MAC accumulator.

Parameters:
MAX_SV, 100, SV memory depth; upper bound on cfg_num_sv
ADDR_W, 7, SV address width; must satisfy 2^ADDR_W >= MAX_SV
MAC_LAT, 2, cycles from mac_en to the product being reflected in mac_fx
FX_W, 48, accumulator (decision value) width

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
test_valid  in  1  test sample offered
test_x  in  9  test feature value
test_ready  out  1  sequencer can accept a sample
cfg_num_sv  in  ADDR_W  active SV count, sampled at accept
sv_rd_en  out  1  SV memory read strobe
sv_addr  out  ADDR_W  SV memory address
sv_alpha  in  9  alpha read data, valid 1 cycle after sv_rd_en
sv_x  in  9  SV feature read data, same timing
sv_y  in  2  signed label read data (+1/-1), same timing
mac_clear  out  1  clear accumulator to 0
mac_en  out  1  accumulate current operands
mac_alpha  out  9  alpha operand
mac_xtest  out  9  latched test sample
mac_xsv  out  9  SV feature operand
mac_y  out  2  signed label operand
mac_fx  in  FX_W  signed accumulated decision value
res_valid  out  1  class result available
res_class  out  2  signed class, +1 or -1
res_ready  in  1  consumer takes result
busy  out  1  high in every state except IDLE

Behaviour:
- States: IDLE, FETCH, DRAIN, DECIDE, HOLD. Encoding is free.
- Reset (any state, including mid-FETCH or HOLD): state=IDLE; test_ready=1 on the following cycle; res_valid=0, res_class=0, sv_rd_en=0, sv_addr=0, mac_en=0, mac_clear=0, busy=0. Any in-flight sample is dropped.
- IDLE: test_ready=1. Accept occurs in cycle T when test_valid && test_ready. At accept: latch test_x into mac_xtest (held until the next accept); latch N=cfg_num_sv, saturating to MAX_SV if larger.
- Cycle T+1: mac_clear=1 for exactly one cycle. If N>0, enter FETCH; if N=0, enter DRAIN directly.
- FETCH: sv_rd_en=1 with sv_addr=0,1,...,N-1, one address per cycle during T+1..T+N. No wrap; the address never reaches N.
- mac_en is sv_rd_en delayed by one cycle (high T+2..T+N+1). mac_alpha, mac_xsv and mac_y pass sv_alpha, sv_x and sv_y through combinationally.
- DRAIN: exactly MAC_LAT+1 cycles after the last FETCH cycle (or after T+1 when N=0).
- DECIDE: one cycle. res_class = +1 if signed mac_fx > 0; otherwise -1. Zero maps to -1. The result is registered.
- HOLD: res_valid=1. res_class is stable until the cycle after res_valid && res_ready. On handshake, return to IDLE; test_ready=1 the next cycle.
- Latency: res_valid first rises at cycle T+N+MAC_LAT+3. The formula also holds for N=0.
- test_ready=0 in all non-IDLE states. test_valid is ignored there; no queuing.
- res_ready asserted early (before res_valid) has no effect. res_class keeps its last value after the handshake until the next DECIDE.
- mac_clear and mac_en are never high in the same cycle.

Test Plan:
- Reset, then cfg_num_sv=3, alpha={1,2,1}, X_sv={1,2,3}, Y={+1,-1,+1}, test_x=1 -> fx=4-18+16=2 -> res_class=+1; res_valid rises exactly 3+MAC_LAT+3 cycles after accept; sv_addr sequence 0,1,2.
- Same SVs with Y={-1,+1,-1} -> fx=-2 -> res_class=-1; mac_clear pulses exactly once per sample.
- Entries chosen so fx is exactly 0 -> res_class=-1. cfg_num_sv=0 -> no sv_rd_en, res_class=-1, latency MAC_LAT+3.
- cfg_num_sv=MAX_SV (100), and separately cfg_num_sv=127 -> 100 reads, last sv_addr=99, latency 100+MAC_LAT+3.
- res_ready held low for 10 cycles -> res_valid and res_class stable, test_ready=0, test_valid pulses ignored. Raise res_ready -> IDLE next cycle, then back-to-back samples are processed.
- Assert reset in the middle of FETCH (addr=40) -> next cycle IDLE, all outputs at reset values. A new sample then classifies correctly from addr 0.
